// File: rtl/gray_ptr_status_pkg.sv
// Shared helpers for Gray-coded FIFO pointer handling: code conversion,
// bit counting and the reset/assignment macros used across the BSV-derived
// pointer logic.

`ifndef BSV_RESET_VALUE
`define BSV_RESET_VALUE 1'b1
`endif

`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

package gray_ptr_status_pkg;

  // Widest pointer the helpers handle; callers zero-extend into word_t.
  localparam int unsigned max_width = 32;

  typedef logic [max_width-1:0] word_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[max_width-1] = g[max_width-1];
    for (int i = max_width - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input word_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < max_width; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync3.sv
// Three-stage capture of a remote-domain Gray pointer. s1/s2 form the
// metastability synchroniser; s3 holds the previous s2 so a pointer that
// moved by more than one Gray step between samples can be flagged.

module gray_sync3
  import gray_ptr_status_pkg::*;
#(
  parameter int              width = 4,
  parameter logic [width-1:0] init = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] remote_gray,
  output logic [width-1:0] sync_gray,
  output logic             step_err
);

  logic [width-1:0] s1;
  logic [width-1:0] s2;
  logic [width-1:0] s3;

  // Shift the remote pointer through the chain; reset forces all stages to init.
  always_ff @(posedge CLK) begin
    if (RST == `BSV_RESET_VALUE) begin
      s1 <= init;
      s2 <= init;
      s3 <= init;
    end else begin
      s1 <= remote_gray;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync_gray = s2;

  // A legal Gray counter changes at most one bit between consecutive samples.
  assign step_err = popcount(word_t'(s2 ^ s3)) > 1;

endmodule

// File: rtl/gray_ptr_status.sv
// Per-domain status block of a dual-clock FIFO. Brings the remote Gray
// pointer into CLK, converts both pointers to binary and derives FULL or
// EMPTY, a registered occupancy LEVEL and a sticky protocol-error flag.

module gray_ptr_status
  import gray_ptr_status_pkg::*;
#(
  parameter int               width      = 4,
  parameter logic [width-1:0] init       = '0,
  parameter bit               write_side = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] LOCAL_GRAY,
  input  logic [width-1:0] REMOTE_GRAY,
  output logic [width-1:0] SYNC_GRAY,
  output logic             FULL,
  output logic             EMPTY,
  output logic [width-1:0] LEVEL,
  output logic             ERR
);

  if (width < 2 || width >= max_width) begin : g_bad_width
    $error("gray_ptr_status: width must be in 2..%0d", max_width - 1);
  end

  // Depth is half the pointer range; the top bit is the wrap indicator.
  localparam logic [width-1:0] depth = {1'b1, {(width - 1){1'b0}}};

  logic [width-1:0] sync_gray;
  logic             step_err;
  word_t            lb_word;
  word_t            rb_word;
  logic [width-1:0] lb;
  logic [width-1:0] rb;
  logic [width-1:0] diff;
  logic             unused_hi;

  gray_sync3 #(
    .width (width),
    .init  (init)
  ) u_sync (
    .CLK         (CLK),
    .RST         (RST),
    .remote_gray (REMOTE_GRAY),
    .sync_gray   (sync_gray),
    .step_err    (step_err)
  );

  assign SYNC_GRAY = sync_gray;

  assign lb_word   = gray2bin(word_t'(LOCAL_GRAY));
  assign rb_word   = gray2bin(word_t'(sync_gray));
  assign lb        = lb_word[width-1:0];
  assign rb        = rb_word[width-1:0];
  assign unused_hi = ^{lb_word[max_width-1:width], rb_word[max_width-1:width]};

  // Modular subtraction absorbs pointer wrap; the writer measures how far it
  // is ahead of the reader, the reader how far the writer is ahead of it.
  assign diff = write_side ? (lb - rb) : (rb - lb);

  // Flags stay combinational so a local pointer move is reflected immediately,
  // while the remote view can only lag, which errs toward FULL/EMPTY.
  assign FULL  = write_side  ? (diff == depth) : 1'b0;
  assign EMPTY = !write_side ? (diff == '0)    : 1'b0;

  // Register occupancy and accumulate protocol errors until reset.
  always_ff @(posedge CLK) begin
    if (RST == `BSV_RESET_VALUE) begin
      LEVEL <= '0;
      ERR   <= 1'b0;
    end else begin
      LEVEL <= diff;
      ERR   <= ERR | step_err | (diff > depth);
    end
  end

endmodule

// File: tb/tb_gray_ptr_status.sv
// Bench for gray_ptr_status: a read-side and a write-side instance share the
// same pointer inputs and are compared every cycle against a pointer-level
// model, with literal expectations pinning the key scenarios.

module tb_gray_ptr_status;

  logic       CLK;
  logic       RST;
  logic [3:0] LOCAL_GRAY;
  logic [3:0] REMOTE_GRAY;

  logic [3:0] rd_sync, wr_sync, rd_level, wr_level;
  logic       rd_full, rd_empty, rd_err, wr_full, wr_empty, wr_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  gray_ptr_status #(.width(4), .init(4'b0000), .write_side(1'b0)) u_rd (
    .CLK(CLK), .RST(RST), .LOCAL_GRAY(LOCAL_GRAY), .REMOTE_GRAY(REMOTE_GRAY),
    .SYNC_GRAY(rd_sync), .FULL(rd_full), .EMPTY(rd_empty), .LEVEL(rd_level), .ERR(rd_err)
  );

  gray_ptr_status #(.width(4), .init(4'b0000), .write_side(1'b1)) u_wr (
    .CLK(CLK), .RST(RST), .LOCAL_GRAY(LOCAL_GRAY), .REMOTE_GRAY(REMOTE_GRAY),
    .SYNC_GRAY(wr_sync), .FULL(wr_full), .EMPTY(wr_empty), .LEVEL(wr_level), .ERR(wr_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- model ----------------
  function automatic int g2b(input logic [3:0] g);
    for (int b = 0; b < 16; b++) begin
      if (4'(b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic logic [3:0] b2g(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic int mdiff(input bit ws, input logic [3:0] s2, input logic [3:0] lg);
    int rb, lb;
    rb = g2b(s2);
    lb = g2b(lg);
    return ws ? (lb - rb + 16) % 16 : (rb - lb + 16) % 16;
  endfunction

  // Remote pointer as seen after the last edges, plus whether each edge reset.
  bit         h_rst[3] = '{1'b1, 1'b1, 1'b1};
  logic [3:0] h_rem[3] = '{4'd0, 4'd0, 4'd0};
  logic [3:0] s2_m = 4'd0;
  logic [3:0] s3_m = 4'd0;
  int         lvl_m[2] = '{0, 0};
  bit         err_m[2] = '{1'b0, 1'b0};

  always @(posedge CLK) begin
    int d;
    for (int w = 0; w < 2; w++) begin
      d = mdiff(w == 1, s2_m, LOCAL_GRAY);
      if (RST) begin
        lvl_m[w] = 0;
        err_m[w] = 1'b0;
      end else begin
        lvl_m[w] = d;
        if ($countones(s2_m ^ s3_m) > 1 || d > 8) err_m[w] = 1'b1;
      end
    end
    h_rst[2] = h_rst[1]; h_rem[2] = h_rem[1];
    h_rst[1] = h_rst[0]; h_rem[1] = h_rem[0];
    h_rst[0] = RST;      h_rem[0] = REMOTE_GRAY;
    s2_m = (h_rst[0] || h_rst[1]) ? 4'd0 : h_rem[1];
    s3_m = (h_rst[0] || h_rst[1] || h_rst[2]) ? 4'd0 : h_rem[2];
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("rd_sync",  int'(rd_sync),  int'(s2_m));
      check("wr_sync",  int'(wr_sync),  int'(s2_m));
      check("rd_empty", int'(rd_empty), int'(mdiff(1'b0, s2_m, LOCAL_GRAY) == 0));
      check("rd_full",  int'(rd_full),  0);
      check("wr_full",  int'(wr_full),  int'(mdiff(1'b1, s2_m, LOCAL_GRAY) == 8));
      check("wr_empty", int'(wr_empty), 0);
      check("rd_level", int'(rd_level), lvl_m[0]);
      check("wr_level", int'(wr_level), lvl_m[1]);
      check("rd_err",   int'(rd_err),   int'(err_m[0]));
      check("wr_err",   int'(wr_err),   int'(err_m[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REMOTE_GRAY = 4'b0000;
    LOCAL_GRAY  = 4'b0000;
    cyc();
    cyc();
    RST = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    RST = 1'b1;
    LOCAL_GRAY  = 4'b0000;
    REMOTE_GRAY = 4'b0101;

    // 1: reset holds everything at init regardless of the remote pointer
    cyc();
    cyc();
    sample();
    check("t1_rd_level", int'(rd_level), 0);
    check("t1_wr_level", int'(wr_level), 0);
    check("t1_rd_err",   int'(rd_err),   0);
    check("t1_wr_err",   int'(wr_err),   0);
    check("t1_sync",     int'(rd_sync),  0);
    check("t1_empty",    int'(rd_empty), 1);
    check("t1_full",     int'(wr_full),  0);
    chk_en = 1'b1;
    do_reset();

    // 2: read side, remote 0000 -> 0001 -> 0011
    REMOTE_GRAY = 4'b0001;
    cyc();
    REMOTE_GRAY = 4'b0011;
    sample();
    check("t2_empty_hold", int'(rd_empty), 1);
    cyc();
    sample();
    check("t2_empty_fall", int'(rd_empty), 0);
    cyc();
    sample();
    check("t2_level1", int'(rd_level), 1);
    cyc();
    sample();
    check("t2_level2", int'(rd_level), 2);
    check("t2_err", int'(rd_err), 0);

    // 3: write side, local jumps to bin 8 -> full, then remote advances
    do_reset();
    LOCAL_GRAY = 4'b1100;
    sample();
    check("t3_full_now", int'(wr_full), 1);
    cyc();
    sample();
    check("t3_level8", int'(wr_level), 8);
    REMOTE_GRAY = 4'b0001;
    cyc();
    sample();
    check("t3_full_hold", int'(wr_full), 1);
    cyc();
    sample();
    check("t3_full_drop", int'(wr_full), 0);
    cyc();
    sample();
    check("t3_level7", int'(wr_level), 7);

    // 4: write side wrap, local 15 -> 0 against remote 12
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      LOCAL_GRAY = b2g(i);
      cyc();
    end
    for (int i = 1; i <= 12; i++) begin
      LOCAL_GRAY  = b2g(i + 3);
      REMOTE_GRAY = b2g(i);
      cyc();
    end
    repeat (4) cyc();
    sample();
    check("t4_remote_gray", int'(REMOTE_GRAY), 'b1010);
    check("t4_level3", int'(wr_level), 3);
    LOCAL_GRAY = 4'b0000;
    sample();
    check("t4_full", int'(wr_full), 0);
    cyc();
    sample();
    check("t4_level4", int'(wr_level), 4);
    check("t4_err", int'(wr_err), 0);

    // 5: remote jumps two bits at once -> sticky error
    do_reset();
    REMOTE_GRAY = 4'b0011;
    cyc();
    cyc();
    sample();
    check("t5_err_early", int'(rd_err), 0);
    cyc();
    sample();
    check("t5_err_set", int'(rd_err), 1);
    repeat (20) cyc();
    sample();
    check("t5_err_sticky", int'(rd_err), 1);
    RST = 1'b1;
    REMOTE_GRAY = 4'b0000;
    cyc();
    sample();
    check("t5_err_clr", int'(rd_err), 0);

    // 6: read side at level 5, one-cycle reset with remote held
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      REMOTE_GRAY = b2g(i);
      cyc();
    end
    repeat (4) cyc();
    sample();
    check("t6_level5", int'(rd_level), 5);
    check("t6_err", int'(rd_err), 0);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    sample();
    check("t6_level0", int'(rd_level), 0);
    cyc();
    sample();
    check("t6_empty_r1", int'(rd_empty), 1);
    cyc();
    sample();
    check("t6_empty_r2", int'(rd_empty), 0);
    check("t6_sync", int'(rd_sync), 'b0111);
    cyc();
    sample();
    check("t6_level_back", int'(rd_level), 5);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
